access_count_sched: RTL and testbench



---
 rtl/access_count_if.sv | 33 +++
 rtl/access_count_sched.sv | 142 ++++++++++++++
 tb/tb_access_count_sched.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/access_count_if.sv
// Bundle for access_count_sched: event inputs, scheduler enable, the read and
// clear request/ack pairs and the sticky status outputs.
//   master: the event source / register block driving requests
//   slave:  the counter block (access_count_sched)
interface access_count_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned CH_W   = 2
);
    logic              en;
    logic [NUM_CH-1:0] ev;
    logic              clr_req;
    logic              clr_all;
    logic [CH_W-1:0]   clr_ch;
    logic              clr_ack;
    logic              rd_req;
    logic [CH_W-1:0]   rd_ch;
    logic              rd_ack;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] drop;

    modport master (
        output en, ev, clr_req, clr_all, clr_ch, rd_req, rd_ch,
        input  clr_ack, rd_ack, rd_data, busy, ovf, drop
    );

    modport slave (
        input  en, ev, clr_req, clr_all, clr_ch, rd_req, rd_ch,
        output clr_ack, rd_ack, rd_data, busy, ovf, drop
    );
endinterface

// File: rtl/access_count_sched.sv
// Per-channel access counters sharing a single increment path.
// Each channel buffers event pulses in a small pending counter; a round-robin
// scheduler commits at most one increment per cycle to the counter bank.
// Ports:
//   clk, nrst     clock, asynchronous active-low reset
//   bus (slave)   en, ev[NUM_CH], clear request/ack, read request/ack/data,
//                 busy, sticky ovf[NUM_CH] and drop[NUM_CH]
module access_count_sched #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned PEND_W = 3,
    parameter int unsigned CH_W   = 2
) (
    input logic           clk,
    input logic           nrst,
    access_count_if.slave bus
);
    logic [WIDTH-1:0]  count_q [NUM_CH];
    logic [WIDTH-1:0]  count_d [NUM_CH];
    logic [PEND_W-1:0] pend_q  [NUM_CH];
    logic [PEND_W-1:0] pend_d  [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d, drop_q, drop_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_ack_q, rd_ack_d;
    logic              clr_ack_q, clr_ack_d;
    logic              busy_q, busy_d;

    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] clr_mask;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   idx;
    logic [WIDTH-1:0]  rd_sel;

    // Grant is decided from registered pending state only, so an event is
    // counted no earlier than the cycle after it was buffered.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cand[i] = (pend_q[i] != '0);
        end
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            idx = CH_W'((int'(ptr_q) + k) % int'(NUM_CH));
            if (bus.en && !gnt_vld && cand[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        if (bus.clr_req) begin
            if (bus.clr_all) begin
                clr_mask = '1;
            end else begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    clr_mask[i] = (CH_W'(i) == bus.clr_ch);
                end
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (CH_W'(i) == bus.rd_ch) rd_sel = count_q[i];
        end
    end

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        busy_d = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            count_d[i] = count_q[i];
            pend_d[i]  = pend_q[i];
            if (clr_mask[i]) begin
                // Clear beats a coincident grant; a coincident event survives.
                count_d[i] = '0;
                ovf_d[i]   = 1'b0;
                drop_d[i]  = 1'b0;
                pend_d[i]  = bus.ev[i] ? PEND_W'(1) : '0;
            end else begin
                if (bus.ev[i] && !(gnt_vld && gnt_ch == CH_W'(i))) begin
                    if (pend_q[i] == '1) drop_d[i] = 1'b1;
                    else                 pend_d[i] = pend_q[i] + PEND_W'(1);
                end else if (!bus.ev[i] && gnt_vld && gnt_ch == CH_W'(i)) begin
                    pend_d[i] = pend_q[i] - PEND_W'(1);
                end
                if (gnt_vld && gnt_ch == CH_W'(i)) begin
                    count_d[i] = count_q[i] + WIDTH'(1);
                    if (count_q[i] == '1) ovf_d[i] = 1'b1;
                end
            end
            busy_d = busy_d | (pend_d[i] != '0);
        end
        // A grant cancelled by a clear does not move the pointer.
        ptr_d     = (gnt_vld && !clr_mask[gnt_ch]) ? gnt_ch : ptr_q;
        rd_data_d = bus.rd_req ? rd_sel : rd_data_q;
        rd_ack_d  = bus.rd_req;
        clr_ack_d = bus.clr_req;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                count_q[i] <= '0;
                pend_q[i]  <= '0;
            end
            ovf_q     <= '0;
            drop_q    <= '0;
            ptr_q     <= '0;
            rd_data_q <= '0;
            rd_ack_q  <= 1'b0;
            clr_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                count_q[i] <= count_d[i];
                pend_q[i]  <= pend_d[i];
            end
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            ptr_q     <= ptr_d;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_ack_d;
            clr_ack_q <= clr_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_ack  = rd_ack_q;
    assign bus.clr_ack = clr_ack_q;
    assign bus.busy    = busy_q;
    assign bus.ovf     = ovf_q;
    assign bus.drop    = drop_q;
endmodule

// File: tb/tb_access_count_sched.sv
module tb_access_count_sched;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 10;
    localparam int unsigned PEND_W = 3;
    localparam int unsigned CH_W   = 2;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [WIDTH-1:0] rd_q [$];
    int               clr_q [$];

    access_count_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CH_W(CH_W)) bus ();

    access_count_sched #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .PEND_W(PEND_W), .CH_W(CH_W)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one read; expected data goes to the scoreboard.
    task automatic rd(input int ch, input int exp);
        bus.rd_req = 1'b1;
        bus.rd_ch  = CH_W'(ch);
        rd_q.push_back(WIDTH'(exp));
        cyc();
        bus.rd_req = 1'b0;
    endtask

    // Monitor: pops an expectation whenever the DUT acknowledges.
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.rd_ack) begin
                n_vec++;
                if (rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_ack_unexpected: got rd_data %0d expected no ack", bus.rd_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = rd_q.pop_front();
                    if (bus.rd_data !== e) begin
                        n_err++;
                        $display("FAIL rd_data: got %0d expected %0d", bus.rd_data, e);
                    end
                end
            end
            if (bus.clr_ack) begin
                n_vec++;
                if (clr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL clr_ack_unexpected: got 1 expected 0");
                end else begin
                    void'(clr_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b1; bus.ev = '0; bus.clr_req = 1'b0; bus.clr_all = 1'b0;
        bus.clr_ch = '0; bus.rd_req = 1'b0; bus.rd_ch = '0;
        #3;
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_flags", {bus.rd_ack, bus.clr_ack, bus.busy}, 0);
        chk("rst_ovf_drop", {bus.ovf, bus.drop}, 0);
        cyc();
        nrst = 1'b1;
        cyc();

        // Round-robin from ptr 0: ch1, ch2, ch3, ch0.
        bus.ev = 4'b1111; cyc(); bus.ev = '0;
        chk("rr_busy_set", 32'(bus.busy), 1);
        rd(1, 0);
        rd(1, 1);
        rd(3, 0);
        chk("rr_busy_mid", 32'(bus.busy), 1);
        rd(0, 0);
        chk("rr_busy_clr", 32'(bus.busy), 0);
        rd(0, 1);
        rd(2, 1);
        rd(3, 1);

        // Single uncontended event: count changes two edges after ev.
        bus.ev = 4'b0010; cyc(); bus.ev = '0;
        chk("single_busy", 32'(bus.busy), 1);
        rd(1, 1);
        chk("single_idle", 32'(bus.busy), 0);
        rd(1, 2);

        // Saturation with scheduler disabled.
        bus.en = 1'b0;
        bus.ev = 4'b0100;
        repeat (9) cyc();
        bus.ev = '0;
        chk("sat_drop", 32'(bus.drop), 32'h4);
        chk("sat_busy", 32'(bus.busy), 1);
        rd(2, 1);
        bus.en = 1'b1;
        repeat (6) cyc();
        chk("sat_drain_busy", 32'(bus.busy), 1);
        cyc();
        chk("sat_drained", 32'(bus.busy), 0);
        rd(2, 8);
        chk("sat_drop_sticky", 32'(bus.drop), 32'h4);

        // Clear ch3 colliding with a grant and an event on ch3.
        bus.ev = 4'b1000; cyc();
        bus.clr_req = 1'b1; bus.clr_ch = 2'd3; clr_q.push_back(1);
        cyc();
        bus.ev = '0; bus.clr_req = 1'b0;
        chk("clr_col_busy", 32'(bus.busy), 1);
        rd(3, 0);
        chk("clr_col_idle", 32'(bus.busy), 0);
        rd(3, 1);

        // Back-to-back clears of ch0 and ch1.
        bus.clr_req = 1'b1; bus.clr_ch = 2'd0; clr_q.push_back(1); cyc();
        bus.clr_ch = 2'd1; clr_q.push_back(1); cyc();
        bus.clr_req = 1'b0;
        rd(0, 0);
        rd(1, 0);

        // Wrap of ch0.
        bus.ev = 4'b0001;
        repeat (1023) cyc();
        bus.ev = '0;
        repeat (3) cyc();
        rd(0, 1023);
        chk("wrap_ovf_pre", 32'(bus.ovf), 0);
        bus.ev = 4'b0001; cyc(); bus.ev = '0;
        repeat (3) cyc();
        rd(0, 0);
        chk("wrap_ovf", 32'(bus.ovf), 32'h1);

        // Clear all, with an event left pending while disabled.
        bus.en = 1'b0;
        bus.ev = 4'b0010; cyc(); bus.ev = '0;
        chk("clrall_busy_pre", 32'(bus.busy), 1);
        bus.clr_req = 1'b1; bus.clr_all = 1'b1; clr_q.push_back(1); cyc();
        bus.clr_req = 1'b0; bus.clr_all = 1'b0;
        chk("clrall_busy", 32'(bus.busy), 0);
        chk("clrall_ovf_drop", {bus.ovf, bus.drop}, 0);
        bus.en = 1'b1;
        cyc();
        rd(1, 0);
        rd(2, 0);
        rd(3, 0);

        // Read and clear ch2 in the same cycle: read sees the pre-clear value.
        bus.ev = 4'b0100;
        repeat (5) cyc();
        bus.ev = '0;
        repeat (2) cyc();
        bus.rd_req = 1'b1; bus.rd_ch = 2'd2; rd_q.push_back(WIDTH'(5));
        bus.clr_req = 1'b1; bus.clr_ch = 2'd2; clr_q.push_back(1);
        cyc();
        bus.rd_req = 1'b0; bus.clr_req = 1'b0;
        rd(2, 0);

        // Reset mid-burst.
        bus.ev = 4'b0001; cyc(); bus.ev = '0; cyc();
        rd(0, 1);
        bus.ev = 4'b1111; cyc(); cyc(); bus.ev = '0;
        #2;
        nrst = 1'b0;
        #1;
        chk("mid_rst_rd_data", 32'(bus.rd_data), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_flags", {bus.rd_ack, bus.clr_ack, bus.ovf, bus.drop}, 0);
        cyc();
        nrst = 1'b1;
        cyc();
        chk("post_rst_busy", 32'(bus.busy), 0);
        rd(0, 0);
        rd(3, 0);
        repeat (2) cyc();

        chk("rd_q_drained", 32'(rd_q.size()), 0);
        chk("clr_q_drained", 32'(clr_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
